// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, frame constants and saturating add for the NN datapath
package nn_pkg;

    localparam int DIN_W       = 20;
    localparam int B_W         = 8;
    localparam int SUM_W       = 24;
    localparam int N_TERMS     = 16;
    localparam int SLOT_CYCLES = 3;
    localparam int PHASE_W     = $clog2(SLOT_CYCLES);
    localparam int SLOT_W      = $clog2(N_TERMS);

    typedef logic signed [DIN_W-1:0] din_t;
    typedef logic signed [B_W-1:0]   bias_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    function automatic sum_t sext_din(input din_t d);
        return {{(SUM_W-DIN_W){d[DIN_W-1]}}, d};
    endfunction

    function automatic sum_t sext_bias(input bias_t v);
        return {{(SUM_W-B_W){v[B_W-1]}}, v};
    endfunction

    // One guard bit exposes overflow; clamp to the representable SUM_W range.
    function automatic sum_t sat_add(input sum_t x, input sum_t y);
        logic signed [SUM_W:0] s;
        s = {x[SUM_W-1], x} + {y[SUM_W-1], y};
        if (s[SUM_W] != s[SUM_W-1])
            return s[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
        return s[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/acc16_bias_accumulator_if.sv
// rtl/acc16_bias_accumulator_if.sv - term/bias inputs and result output of the accumulator
interface acc16_bias_accumulator_if;
    import nn_pkg::*;

    din_t  din;
    bias_t b;
    sum_t  sum;

    modport master (output din, output b, input sum);
    modport slave  (input din, input b, output sum);

endinterface

// File: rtl/acc16_seq.sv
// rtl/acc16_seq.sv - phase/slot sequencer marking the sample edge and the final slot
module acc16_seq
    import nn_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic sample_en_o,
    output logic last_slot_o
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(N_TERMS - 1);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;

    assign sample_en_o = (phase_q == PHASE_LAST);
    assign last_slot_o = (slot_q == SLOT_LAST);

    always_comb begin
        phase_d = sample_en_o ? '0 : phase_q + 1'b1;
        slot_d  = slot_q;
        if (sample_en_o)
            slot_d = last_slot_o ? '0 : slot_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            slot_q  <= '0;
        end else begin
            phase_q <= phase_d;
            slot_q  <= slot_d;
        end
    end

endmodule

// File: rtl/acc16_bias_accumulator.sv
// rtl/acc16_bias_accumulator.sv - 16-term free-running accumulator with saturating bias add
module acc16_bias_accumulator
    import nn_pkg::*;
(
    input logic                    clk,
    input logic                    rst,
    acc16_bias_accumulator_if.slave bus
);

    logic sample_en;
    logic last_slot;
    sum_t acc_q, acc_d;
    sum_t sum_q, sum_d;
    sum_t term_sum;

    acc16_seq u_seq (
        .clk         (clk),
        .rst         (rst),
        .sample_en_o (sample_en),
        .last_slot_o (last_slot)
    );

    // Sixteen DIN_W terms cannot overflow SUM_W, so only the bias add needs clamping.
    assign term_sum = acc_q + sext_din(bus.din);

    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (sample_en) begin
            if (last_slot) begin
                sum_d = sat_add(term_sum, sext_bias(bus.b));
                acc_d = '0;
            end else begin
                acc_d = term_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign bus.sum = sum_q;

endmodule

// File: tb/tb_acc16_bias_accumulator.sv
// tb/tb_acc16_bias_accumulator.sv - directed self-checking bench for the bias accumulator
module tb_acc16_bias_accumulator;
    import nn_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    sum_t prev_exp;

    acc16_bias_accumulator_if bus ();

    acc16_bias_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        din_t  d;
        bias_t bb;
        sum_t  exp;
        string name;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [SUM_W-1:0] act, input logic [SUM_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: constant din/b; 1: per-slot ramp; 2: junk on phases 0/1, value only on phase 2
    task automatic run_frame(input int mode, input din_t dval, input bias_t bval,
                             input sum_t exp, input string name);
        for (int e = 0; e < N_TERMS * SLOT_CYCLES; e++) begin
            int slot;
            int phase;
            slot  = e / SLOT_CYCLES;
            phase = e % SLOT_CYCLES;
            case (mode)
                1: begin
                    bus.din = (slot == 0) ? din_t'(10) : din_t'(slot);
                    bus.b   = (slot == 0) ? bias_t'(0) : bias_t'(1);
                end
                2: begin
                    bus.din = (phase == 2) ? dval : ((phase == 0) ? din_t'(20'h12345) : din_t'(20'h7FFFF));
                    bus.b   = bval;
                end
                default: begin
                    bus.din = dval;
                    bus.b   = bval;
                end
            endcase
            tick();
            if (e == N_TERMS * SLOT_CYCLES - 2)
                check({name, "_hold"}, bus.sum, prev_exp);
            if (e == N_TERMS * SLOT_CYCLES - 1)
                check(name, bus.sum, exp);
        end
        prev_exp = exp;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        prev_exp = '0;

        vecs[0] = '{d: 20'sd1,       bb: 8'sd1,    exp: 24'sd17,       name: "const_1_f1"};
        vecs[1] = '{d: 20'sd1,       bb: 8'sd1,    exp: 24'sd17,       name: "const_1_f2"};
        vecs[2] = '{d: -20'sd1,      bb: -8'sd8,   exp: 24'hFFFFE8,    name: "neg_1"};
        vecs[3] = '{d: 20'h7FFFF,    bb: 8'sd127,  exp: 24'h7FFFFF,    name: "sat_pos"};
        vecs[4] = '{d: 20'h80000,    bb: -8'sd128, exp: 24'h800000,    name: "sat_neg"};
        vecs[5] = '{d: 20'h01000,    bb: -8'sd5,   exp: 24'h00FFFB,    name: "mixed"};
        vecs[6] = '{d: 20'hC0000,    bb: 8'sd0,    exp: 24'hC00000,    name: "neg_big"};

        rst     = 1'b0;
        bus.din = 20'sd5;
        bus.b   = 8'sd3;
        for (int i = 0; i < 10; i++) tick();
        check("reset_hold", bus.sum, 24'h0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++)
            run_frame(0, vecs[i].d, vecs[i].bb, vecs[i].exp, vecs[i].name);

        run_frame(1, '0, '0, 24'sd131, "per_slot");
        run_frame(2, 20'sd2, 8'sd0, 24'sd32, "sample_point");

        bus.din = 20'sd7;
        bus.b   = 8'sd0;
        for (int i = 0; i < 20; i++) tick();
        check("pre_reset_sum", bus.sum, 24'sd32);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset", bus.sum, 24'h0);
        for (int i = 0; i < 3; i++) tick();
        check("reset_held", bus.sum, 24'h0);
        rst      = 1'b1;
        prev_exp = '0;
        run_frame(0, 20'sd3, 8'sd0, 24'sd48, "restart_frame");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
